// File: rtl/serial_byte_loader.sv
// serial_byte_loader: assembles a framed serial bit stream (start, WIDTH data,
// optional even parity, stop) into a parallel word on DATA. ENA strobes for
// one cycle per good frame; bad frames pulse FERR/PERR and leave DATA alone.
// Optional feature: define PARITY_EN to add the even-parity bit to each frame.
module serial_byte_loader #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SIN,
   input  logic             SVALID,
   output logic [WIDTH-1:0] DATA,
   output logic             ENA,
   output logic             BUSY,
   output logic             FERR,
   output logic             PERR
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               ena_q, ena_d;
   logic               ferr_q, ferr_d;
   logic               busy_q, busy_d;
`ifdef PARITY_EN
   logic               perr_q, perr_d;
   logic               pend_q, pend_d;
`endif

   // Next-state, datapath and strobe computation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      ena_d   = 1'b0;
      ferr_d  = 1'b0;
`ifdef PARITY_EN
      perr_d  = 1'b0;
      pend_d  = pend_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (SVALID && !SIN) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
`ifdef PARITY_EN
               pend_d  = 1'b0;
`endif
            end
         end
         ST_SHIFT: begin
            if (SVALID) begin
               // Shifting in from one end leaves the first bit at the far end
               if (MSB_FIRST != 0) shift_d = {shift_q[WIDTH-2:0], SIN};
               else                shift_d = {SIN, shift_q[WIDTH-1:1]};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef PARITY_EN
         ST_PAR: begin
            if (SVALID) begin
               pend_d  = ^{shift_q, SIN};
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (SVALID) begin
               state_d = ST_IDLE;
               if (!SIN) begin
                  ferr_d = 1'b1;
`ifdef PARITY_EN
               end else if (pend_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  data_d = shift_q;
                  ena_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; synchronous reset has priority
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ena_q   <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef PARITY_EN
         perr_q  <= 1'b0;
         pend_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ena_q   <= ena_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef PARITY_EN
         perr_q  <= perr_d;
         pend_q  <= pend_d;
`endif
      end
   end

   assign DATA = data_q;
   assign ENA  = ena_q;
   assign BUSY = busy_q;
   assign FERR = ferr_q;
`ifdef PARITY_EN
   assign PERR = perr_q;
`else
   assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: directed frames plus random frames, checked
// every cycle against a frame-level model of the expected word and strobes.
module tb_serial_byte_loader;

   logic       CLK = 1'b0;
   logic       RST;
   logic       SIN;
   logic       SVALID;
   logic [7:0] DATA, DATA_M;
   logic       ENA, BUSY, FERR, PERR;
   logic       ENA_M, BUSY_M, FERR_M, PERR_M;

   int tests = 0;
   int fails = 0;
   logic [7:0] model_data = 8'h00;

   serial_byte_loader #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
      .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID),
      .DATA(DATA), .ENA(ENA), .BUSY(BUSY), .FERR(FERR), .PERR(PERR)
   );

   serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
      .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID),
      .DATA(DATA_M), .ENA(ENA_M), .BUSY(BUSY_M), .FERR(FERR_M), .PERR(PERR_M)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input, then sample 1 time unit after the edge
   task automatic tick(input logic sv, input logic sin);
      SVALID = sv;
      SIN    = sin;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic e_ena, input logic e_ferr,
                             input logic e_perr, input logic e_busy);
      check({tag, ".ena"},    32'(ENA),    32'(e_ena));
      check({tag, ".ferr"},   32'(FERR),   32'(e_ferr));
      check({tag, ".perr"},   32'(PERR),   32'(e_perr));
      check({tag, ".busy"},   32'(BUSY),   32'(e_busy));
      check({tag, ".data"},   32'(DATA),   32'(model_data));
      check({tag, ".data_m"}, 32'(DATA_M), 32'(rev8(model_data)));
      check({tag, ".ena_m"},  32'(ENA_M),  32'(e_ena));
   endtask

   // Send one frame LSB-first with optional random gaps; checks every cycle
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good,
                             input int unsigned max_gap, input string tag);
      logic bits[$];
      logic par_ok;
      logic good;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef PARITY_EN
      bits.push_back((^d) ^ !par_good);
      par_ok = par_good;
`else
      par_ok = 1'b1;
`endif
      bits.push_back(stop);
      for (int i = 0; i < bits.size(); i++) begin
         if (i > 0 && max_gap > 0) begin
            repeat ($urandom_range(max_gap, 0)) begin
               tick(1'b0, 1'($urandom_range(1, 0)));
               check_outs({tag, ".gap"}, 1'b0, 1'b0, 1'b0, 1'b1);
            end
         end
         tick(1'b1, bits[i]);
         if (i < bits.size() - 1) begin
            check_outs({tag, ".bit"}, 1'b0, 1'b0, 1'b0, 1'b1);
         end else begin
            good = stop && par_ok;
            if (good) model_data = d;
            check_outs({tag, ".end"}, good, !stop, stop && !par_ok, 1'b0);
         end
      end
   endtask

   initial begin
      RST = 1'b1; SVALID = 1'b0; SIN = 1'b1;
      @(posedge CLK); @(posedge CLK); #1;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      tick(1'b1, 1'b1);
      check_outs("mark", 1'b0, 1'b0, 1'b0, 1'b0);

      // 1: good frame A5, then the strobe must drop
      send_frame(8'hA5, 1'b1, 1'b1, 0, "s1");
      tick(1'b0, 1'b1);
      check_outs("s1.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // 2: bad stop bit
      send_frame(8'hA5, 1'b0, 1'b1, 0, "s2");
      tick(1'b0, 1'b1);
      check_outs("s2.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // 3: gaps between bits
      send_frame(8'h3C, 1'b1, 1'b1, 5, "s3");
      tick(1'b0, 1'b1);
      check_outs("s3.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // 4: reset after the 4th data bit, then a full frame
      tick(1'b1, 1'b0);
      check_outs("s4.start", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'(i % 2));
         check_outs("s4.part", 1'b0, 1'b0, 1'b0, 1'b1);
      end
      RST = 1'b1;
      tick(1'b1, 1'b1);
      RST = 1'b0;
      model_data = 8'h00;
      check_outs("s4.rst", 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1);
      check_outs("s4.idle", 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1, 1'b1, 0, "s4");

      // 5: back-to-back frames
      send_frame(8'hFF, 1'b1, 1'b1, 0, "s5a");
      send_frame(8'h00, 1'b1, 1'b1, 0, "s5b");
      tick(1'b0, 1'b1);
      check_outs("s5.after", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_EN
      // 6: wrong then right parity
      send_frame(8'h07, 1'b1, 1'b0, 0, "s6a");
      tick(1'b0, 1'b1);
      check_outs("s6a.after", 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, 0, "s6b");
      tick(1'b0, 1'b1);
      check_outs("s6b.after", 1'b0, 1'b0, 1'b0, 1'b0);
      // bad parity and bad stop: framing error wins
      send_frame(8'h5A, 1'b0, 1'b0, 0, "s6c");
`endif

      // random frames with idle marks, gaps, bad stops and bad parity
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(2, 0)) begin
            tick(1'b1, 1'b1);
            check_outs("rnd.mark", 1'b0, 1'b0, 1'b0, 1'b0);
         end
         send_frame(8'($urandom), ($urandom_range(3, 0) != 0),
                    ($urandom_range(3, 0) != 0), 3, "rnd");
      end
      tick(1'b0, 1'b1);
      check_outs("rnd.after", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
